rep3_serial_encoder: RTL and testbench
======================================

// Module: rep3_serial_encoder
//
// PURPOSE
//   Transmit end of the triple-redundancy serial link. The majority-vote (pair/triple)
//   detector is the receive end. This block accepts an NBITS word over a val/rdy handshake.
//   It sends the word LSB-first on a single wire, repeating each data bit for three
//   consecutive cycles ("chips"). A downstream 3-input majority voter on each chip group
//   recovers the bit even if one chip is corrupted.
//
// PARAMETERS
//   NBITS   8   data word width; legal range 2..32
//
// PORTS
//   clk        input   1      clock, rising edge
//   rst        input   1      asynchronous reset, active-high
//   in_val     input   1      upstream word valid
//   in_rdy     output  1      encoder can accept a word
//   in_msg     input   NBITS  word to transmit, sampled on handshake
//   out_val    output  1      out_bit carries a valid chip this cycle
//   out_bit    output  1      serial chip, equal to the current data bit
//   out_first  output  1      first chip of frame (bit 0, chip 0)
//   out_last   output  1      last chip of frame (bit NBITS-1, chip 2)
//
// BEHAVIOUR
//   - Reset (async, while rst=1): state=IDLE, msg_reg=0, bit_idx=0, chip_cnt=0.
//     All outputs are 0 while rst=1, including in_rdy.
//   - After reset releases: in_rdy=1, out_val=out_bit=out_first=out_last=0.
//   - FSM states: IDLE, SEND.
//     - IDLE:
//       - in_rdy=1, out_val=0.
//       - On in_val&&in_rdy at an edge: msg_reg<=in_msg, bit_idx<=0, chip_cnt<=0,
//         state<=SEND.
//       - Otherwise hold.
//     - SEND:
//       - in_rdy=0, out_val=1, out_bit=msg_reg[bit_idx].
//       - chip_cnt counts 0,1,2; at 2 it wraps to 0 and bit_idx increments.
//       - When bit_idx==NBITS-1 and chip_cnt==2, state<=IDLE at that edge.
//   - Latency and throughput:
//     - First chip appears the cycle after the accepting edge.
//     - A frame is exactly 3*NBITS consecutive out_val cycles, with no gaps.
//     - in_rdy returns to 1 the cycle after out_last; no back-to-back overlap.
//     - Peak throughput is one word per 3*NBITS+1 cycles.
//   - Flag timing: out_first=1 iff SEND && bit_idx==0 && chip_cnt==0.
//     out_last=1 iff SEND && bit_idx==NBITS-1 && chip_cnt==2.
//   - Outputs are pure functions of registered state; there is no comb path from in_* to out_*.
//   - Width rules: bit_idx is $clog2(NBITS) bits. chip_cnt is 2 bits and never reaches 3.
//   - Input changes: in_msg/in_val changes during SEND are ignored; msg_reg is stable for the
//     whole frame.
//   - in_val held high continuously: a new word is accepted on every IDLE cycle, i.e. the
//     cycle after each out_last.
//   - rst asserted mid-frame: the frame aborts immediately. out_val drops to 0 without edge
//     dependence and no partial chips follow. After release the block is IDLE with in_rdy=1.
//
// TESTING
//   1. Reset values: assert rst with no clock edge -> all outputs 0.
//      Release rst -> in_rdy=1, out_val=0.
//   2. NBITS=8, in_msg=8'hA5 accepted -> 24 chips 111_000_111_000_000_111_000_111.
//      out_first on chip 1, out_last on chip 24, in_rdy=1 on the next cycle.
//   3. in_val high with in_msg=8'h01 then 8'hFF, held continuously:
//      - second handshake occurs exactly one cycle after the first frame's out_last;
//      - frame 2 is 24 ones;
//      - in_msg changes mid-frame never alter the chips.
//   4. Mid-frame reset: assert rst asynchronously during chip 10 of 8'h3C -> out_val=0
//      immediately. Release, then send 8'h80 -> 21 zero chips then 3 one chips.
//   5. Idle hold: in_val=0 for 20 cycles -> out_val stays 0, in_rdy stays 1, no state change.
//   6. NBITS=2 build, in_msg=2'b10 -> chips 000_111, out_first and out_last 5 cycles apart.

Source files
------------

// File: rtl/rep3_serial_encoder.sv
// -----------------------------------------------------------------------------
// rep3_serial_encoder
//
// Transmit end of the triple-redundancy serial link. A word of NBITS bits is
// accepted over a val/rdy handshake and sent LSB-first on a single wire. Each
// data bit is repeated for three consecutive cycles ("chips") so that a 3-input
// majority voter at the receive end can recover the bit even when one chip of
// the group is corrupted.
//
// Parameters
//   NBITS      data word width, legal range 2..32
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active-high
//   in_val     upstream word valid
//   in_rdy     encoder can accept a word (0 while rst=1)
//   in_msg     word to transmit, sampled on the handshake edge
//   out_val    out_bit carries a valid chip this cycle
//   out_bit    serial chip, equal to the current data bit
//   out_first  first chip of the frame (bit 0, chip 0)
//   out_last   last chip of the frame (bit NBITS-1, chip 2)
//
// Handshake: a word transfers on a rising clk edge where in_val && in_rdy are
// both 1. in_rdy does not depend on in_val. On the output side there is no
// back-pressure: while out_val=1 the receiver must take one chip per cycle.
//
// Timing: the first chip appears the cycle after the accepting edge, a frame
// is exactly 3*NBITS consecutive out_val cycles, and in_rdy returns the cycle
// after out_last. Peak throughput is one word per 3*NBITS+1 cycles.
// -----------------------------------------------------------------------------
module rep3_serial_encoder #(
  parameter int NBITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [NBITS-1:0] in_msg,
  output logic             out_val,
  output logic             out_bit,
  output logic             out_first,
  output logic             out_last
);

  localparam int IDXW = $clog2(NBITS);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBITS - 1);
  localparam logic [1:0] LAST_CHIP = 2'd2;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Registered state. `state` is the single point to bind FSM checkers to.
  state_t            state;
  state_t            state_nxt;
  logic [NBITS-1:0]  msg_reg;
  logic [NBITS-1:0]  msg_nxt;
  logic [IDXW-1:0]   bit_idx;
  logic [IDXW-1:0]   bit_idx_nxt;
  logic [1:0]        chip_cnt;
  logic [1:0]        chip_cnt_nxt;

  logic              sending;
  logic              in_fire;
  logic              bit_done;
  logic              frame_done;

  assign sending    = (state == SEND);
  assign bit_done   = (chip_cnt == LAST_CHIP);
  assign frame_done = sending && (bit_idx == LAST_IDX) && bit_done;

  // in_rdy is gated by rst so it reads 0 for the whole reset pulse, not only
  // after the state register has been cleared.
  assign in_rdy  = (state == IDLE) && !rst;
  assign in_fire = in_val && in_rdy;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      msg_reg  <= '0;
      bit_idx  <= '0;
      chip_cnt <= '0;
    end else begin
      state    <= state_nxt;
      msg_reg  <= msg_nxt;
      bit_idx  <= bit_idx_nxt;
      chip_cnt <= chip_cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt    = state;
    msg_nxt      = msg_reg;
    bit_idx_nxt  = bit_idx;
    chip_cnt_nxt = chip_cnt;

    case (state)
      IDLE: begin
        if (in_fire) begin
          msg_nxt      = in_msg;
          bit_idx_nxt  = '0;
          chip_cnt_nxt = '0;
          state_nxt    = SEND;
        end
      end

      SEND: begin
        // msg_reg is frozen for the whole frame; in_msg/in_val are ignored.
        if (bit_done) begin
          chip_cnt_nxt = '0;
          if (frame_done) begin
            // Park the index at 0 rather than letting it run past NBITS-1
            // when NBITS is not a power of two.
            bit_idx_nxt = '0;
            state_nxt   = IDLE;
          end else begin
            bit_idx_nxt = bit_idx + 1'b1;
          end
        end else begin
          chip_cnt_nxt = chip_cnt + 2'd1;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: functions of registered state only. Because the state register
  // clears asynchronously, out_* drop to 0 as soon as rst rises, even mid-frame.
  // ---------------------------------------------------------------------------
  always_comb begin
    out_val   = sending;
    out_bit   = sending && msg_reg[bit_idx];
    out_first = sending && (bit_idx == '0) && (chip_cnt == 2'd0);
    out_last  = frame_done;
  end

endmodule

// File: tb/tb_rep3_serial_encoder.sv
// -----------------------------------------------------------------------------
// tb_rep3_serial_encoder
//
// Bench for rep3_serial_encoder. Main instance uses NBITS=8; a second instance
// with NBITS=2 covers the narrowest legal width. Expected chips for every
// accepted word are pushed into exp_q as {first, last, bit} and popped by an
// independent monitor on the falling edge.
// -----------------------------------------------------------------------------
module tb_rep3_serial_encoder;

  localparam int NB  = 8;
  localparam int NB2 = 2;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    #20;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // DUTs
  // ---------------------------------------------------------------------------
  logic          in_val;
  logic          in_rdy;
  logic [NB-1:0] in_msg;
  logic          out_val;
  logic          out_bit;
  logic          out_first;
  logic          out_last;

  rep3_serial_encoder #(.NBITS(NB)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_val    (in_val),
    .in_rdy    (in_rdy),
    .in_msg    (in_msg),
    .out_val   (out_val),
    .out_bit   (out_bit),
    .out_first (out_first),
    .out_last  (out_last)
  );

  logic           in_val2;
  logic           in_rdy2;
  logic [NB2-1:0] in_msg2;
  logic           out_val2;
  logic           out_bit2;
  logic           out_first2;
  logic           out_last2;

  rep3_serial_encoder #(.NBITS(NB2)) u_dut2 (
    .clk       (clk),
    .rst       (rst),
    .in_val    (in_val2),
    .in_rdy    (in_rdy2),
    .in_msg    (in_msg2),
    .out_val   (out_val2),
    .out_bit   (out_bit2),
    .out_first (out_first2),
    .out_last  (out_last2)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  logic [2:0] exp_q[$];      // {first, last, bit} per chip
  int n_cmp = 0;
  int n_err = 0;
  int exp_first_cyc = -1;
  int last_cyc = -100;
  int chips_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: each data bit, LSB first, appears as three identical chips.
  task automatic push_exp(input logic [NB-1:0] msg);
    for (int i = 0; i < NB; i++) begin
      for (int c = 0; c < 3; c++) begin
        exp_q.push_back({(i == 0 && c == 0), (i == NB - 1 && c == 2), msg[i]});
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  logic prev_mid = 1'b0;
  logic after_last = 1'b0;

  always @(negedge clk) begin
    logic [2:0] e;
    if (rst) begin
      check("rst_out_val", out_val, 0);
      check("rst_in_rdy", in_rdy, 0);
      prev_mid   = 1'b0;
      after_last = 1'b0;
    end else begin
      if (after_last) begin
        check("rdy_after_last", in_rdy, 1);
        after_last = 1'b0;
      end
      if (out_val) begin
        check("busy_in_rdy", in_rdy, 0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_chip: got chip {f,l,b}=%b%b%b, expected no chip (t=%0t)",
                   out_first, out_last, out_bit, $time);
        end else begin
          e = exp_q.pop_front();
          check("chip", {29'd0, out_first, out_last, out_bit}, {29'd0, e});
        end
        if (out_first) check("first_latency", cyc, exp_first_cyc);
        chips_seen++;
        if (out_last) begin
          last_cyc   = cyc;
          after_last = 1'b1;
        end
        prev_mid = !out_last;
      end else begin
        if (prev_mid) check("frame_gap", out_val, 1);
        check("idle_flags", {29'd0, out_first, out_last, out_bit}, 0);
        prev_mid = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Present msg from the next falling edge until accepted. Returns just after
  // the accepting edge; keep=1 leaves in_val asserted.
  task automatic send(input logic [NB-1:0] msg, input bit keep);
    int t = 0;
    @(negedge clk);
    in_val = 1'b1;
    in_msg = msg;
    while (!in_rdy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_rdy) begin
      check("accept_timeout", in_rdy, 1);
      in_val = 1'b0;
      return;
    end
    exp_first_cyc = cyc + 1;
    push_exp(msg);
    @(posedge clk);
    #1;
    if (!keep) in_val = 1'b0;
    in_msg = NB'($urandom);
  endtask

  // Wait for all expected chips, scrambling in_msg meanwhile.
  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      in_msg = NB'($urandom);
      t++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    @(negedge clk);
  endtask

  task automatic send2(input logic [NB2-1:0] msg);
    int t = 0;
    logic [2:0] e;
    @(negedge clk);
    in_val2 = 1'b1;
    in_msg2 = msg;
    while (!in_rdy2 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("n2_accept", in_rdy2, 1);
    @(posedge clk);
    #1;
    in_val2 = 1'b0;
    in_msg2 = NB2'($urandom);
    for (int k = 0; k < 3 * NB2; k++) begin
      @(negedge clk);
      e = {(k == 0), (k == 3 * NB2 - 1), msg[k / 3]};
      check("n2_chip", {28'd0, out_val2, out_first2, out_last2, out_bit2}, {28'd0, 1'b1, e});
    end
    @(negedge clk);
    check("n2_rdy_after_last", in_rdy2, 1);
    check("n2_val_after_last", out_val2, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus sequence
  // ---------------------------------------------------------------------------
  initial begin
    int t;
    rst     = 1'b0;
    in_val  = 1'b0;
    in_msg  = '0;
    in_val2 = 1'b0;
    in_msg2 = '0;

    // Reset asserted with no clock edge yet.
    #1 rst = 1'b1;
    #1;
    check("rst_noclk_in_rdy", in_rdy, 0);
    check("rst_noclk_outs", {28'd0, out_val, out_bit, out_first, out_last}, 0);
    check("rst_noclk_in_rdy2", in_rdy2, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_rdy", in_rdy, 1);
    check("post_rst_outs", {28'd0, out_val, out_bit, out_first, out_last}, 0);

    // Known pattern 0xA5.
    send(8'hA5, 1'b0);
    drain();

    // Continuous in_val: 0x01 then 0xFF, second accept on the first idle cycle.
    send(8'h01, 1'b1);
    t = 0;
    @(negedge clk);
    while (!in_rdy && t < 100) begin
      in_msg = NB'($urandom);
      @(negedge clk);
      t++;
    end
    check("b2b_accept_cycle", cyc, last_cyc + 1);
    in_msg = 8'hFF;
    exp_first_cyc = cyc + 1;
    push_exp(8'hFF);
    @(posedge clk);
    #1;
    in_val = 1'b0;
    drain();

    // Mid-frame reset during chip 10 of 0x3C.
    chips_seen = 0;
    send(8'h3C, 1'b0);
    t = 0;
    while (chips_seen < 9 && t < 100) begin
      @(posedge clk);
      t++;
    end
    check("abort_chip_count", chips_seen, 9);
    #1 rst = 1'b1;
    #1;
    check("abort_out_val", out_val, 0);
    check("abort_outs", {29'd0, out_bit, out_first, out_last}, 0);
    check("abort_in_rdy", in_rdy, 0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_release_rdy", in_rdy, 1);
    check("abort_release_val", out_val, 0);

    send(8'h80, 1'b0);
    drain();

    // Idle hold.
    in_val = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_msg = NB'($urandom);
      check("idle_rdy", in_rdy, 1);
      check("idle_val", out_val, 0);
    end

    // Random words, some back-to-back.
    for (int n = 0; n < 8; n++) begin
      send(NB'($urandom), 1'b0);
      if ($urandom_range(0, 1) == 1) drain();
    end
    drain();

    // NBITS=2 instance.
    send2(2'b10);
    for (int n = 0; n < 4; n++) send2(NB2'($urandom));

    check("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Watchdog.
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
